// File: rtl/reg_file16_wr.sv
// Register file write side: 1-to-16 write decoder, sixteen WIDTH-bit registers and two
// combinational 16:1 read ports with optional same-cycle write forwarding.
module reg_file16_wr #(
   parameter int unsigned WIDTH   = 16,
   parameter bit          R0_ZERO = 1'b1,
   parameter bit          BYPASS  = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr_en,
   input  logic [3:0]       wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic [3:0]       rd_addr1,
   input  logic [3:0]       rd_addr2,
   output logic [WIDTH-1:0] rd_data1,
   output logic [WIDTH-1:0] rd_data2,
   output logic [15:0]      wr_onehot
);

   logic [WIDTH-1:0] regs_q [16];
   logic [WIDTH-1:0] regs_d [16];

   logic [3:0]       rd_addr [2];
   logic [WIDTH-1:0] rd_data [2];
   logic [WIDTH-1:0] grp_val [2][4];

   assign rd_addr[0] = rd_addr1;
   assign rd_addr[1] = rd_addr2;
   assign rd_data1   = rd_data[0];
   assign rd_data2   = rd_data[1];

   always_comb begin
      wr_onehot = '0;
      for (int k = 0; k < 16; k++) begin
         wr_onehot[k] = wr_en && (wr_addr == 4'(k));
      end
      if (R0_ZERO) begin
         wr_onehot[0] = 1'b0;
      end
   end

   always_comb begin
      for (int k = 0; k < 16; k++) begin
         regs_d[k] = wr_onehot[k] ? wr_data : regs_q[k];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < 16; k++) begin
            regs_q[k] <= '0;
         end
      end else begin
         for (int k = 0; k < 16; k++) begin
            regs_q[k] <= regs_d[k];
         end
      end
   end

   // Low address bits pick within each group of four, high bits pick the group.
   // Forwarding is gated by rst_n so reads stay zero while the write is blocked.
   always_comb begin
      for (int p = 0; p < 2; p++) begin
         for (int g = 0; g < 4; g++) begin
            grp_val[p][g] = regs_q[{2'(g), rd_addr[p][1:0]}];
         end
         rd_data[p] = grp_val[p][rd_addr[p][3:2]];
         if (BYPASS && rst_n && wr_en && (wr_addr == rd_addr[p])) begin
            rd_data[p] = wr_data;
         end
         if (R0_ZERO && (rd_addr[p] == 4'd0)) begin
            rd_data[p] = '0;
         end
      end
   end

endmodule

// File: tb/tb_reg_file16_wr.sv
// Directed bench for reg_file16_wr: a forwarding instance and a non-forwarding instance
// share the same stimulus; expected values are hand-computed constants.
module tb_reg_file16_wr;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        wr_en;
   logic [3:0]  wr_addr;
   logic [15:0] wr_data;
   logic [3:0]  rd_addr1;
   logic [3:0]  rd_addr2;
   logic [15:0] rd1, rd2, oh;
   logic [15:0] rd1_nb, rd2_nb, oh_nb;

   int n_vec = 0;
   int n_err = 0;

   reg_file16_wr #(.WIDTH(16), .R0_ZERO(1'b1), .BYPASS(1'b1)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .rd_addr1  (rd_addr1),
      .rd_addr2  (rd_addr2),
      .rd_data1  (rd1),
      .rd_data2  (rd2),
      .wr_onehot (oh)
   );

   reg_file16_wr #(.WIDTH(16), .R0_ZERO(1'b1), .BYPASS(1'b0)) dut_nb (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .rd_addr1  (rd_addr1),
      .rd_addr2  (rd_addr2),
      .rd_data1  (rd1_nb),
      .rd_data2  (rd2_nb),
      .wr_onehot (oh_nb)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Drive a write on the falling edge and let it commit on the next rising edge.
   task automatic write_reg(input logic [3:0] a, input logic [15:0] d);
      @(negedge clk);
      wr_en   = 1'b1;
      wr_addr = a;
      wr_data = d;
      @(posedge clk);
      #1;
      wr_en   = 1'b0;
   endtask

   initial begin
      rst_n    = 1'b0;
      wr_en    = 1'b0;
      wr_addr  = '0;
      wr_data  = '0;
      rd_addr1 = '0;
      rd_addr2 = '0;

      // Reset: every address reads zero, no decode without wr_en
      for (int i = 0; i < 16; i++) begin
         rd_addr1 = 4'(i);
         rd_addr2 = 4'(15 - i);
         #1;
         chk("reset_rd1", rd1, 16'h0000);
         chk("reset_rd2", rd2, 16'h0000);
      end
      chk("reset_onehot", oh, 16'h0000);

      @(negedge clk);
      rst_n = 1'b1;

      // Write/read all non-zero registers
      for (int k = 1; k < 16; k++) begin
         @(negedge clk);
         wr_en    = 1'b1;
         wr_addr  = 4'(k);
         wr_data  = 16'h1000 + 16'(k);
         rd_addr1 = 4'(k);
         #1;
         chk("wr_onehot", oh, 16'h0001 << k);
         @(posedge clk);
         #1;
         chk("wr_rd1", rd1, 16'h1000 + 16'(k));
         chk("wr_rd1_nb", rd1_nb, 16'h1000 + 16'(k));
      end
      wr_en = 1'b0;

      // R0 writes are discarded
      @(negedge clk);
      wr_en    = 1'b1;
      wr_addr  = 4'd0;
      wr_data  = 16'hBEEF;
      rd_addr1 = 4'd0;
      #1;
      chk("r0_onehot", oh, 16'h0000);
      chk("r0_rd_before", rd1, 16'h0000);
      @(posedge clk);
      #1;
      chk("r0_rd_after", rd1, 16'h0000);
      chk("r0_rd_after_nb", rd1_nb, 16'h0000);
      wr_en = 1'b0;

      // Forwarding vs. no forwarding
      write_reg(4'd5, 16'h1111);
      @(negedge clk);
      wr_en    = 1'b1;
      wr_addr  = 4'd5;
      wr_data  = 16'h2222;
      rd_addr1 = 4'd5;
      rd_addr2 = 4'd5;
      #1;
      chk("byp_rd1", rd1, 16'h2222);
      chk("byp_rd2", rd2, 16'h2222);
      chk("nobyp_rd1_before", rd1_nb, 16'h1111);
      chk("nobyp_rd2_before", rd2_nb, 16'h1111);
      @(posedge clk);
      #1;
      chk("nobyp_rd1_after", rd1_nb, 16'h2222);
      chk("nobyp_rd2_after", rd2_nb, 16'h2222);
      chk("byp_rd1_after", rd1, 16'h2222);
      wr_en = 1'b0;

      // Async reset mid-cycle with a write pending to r15
      write_reg(4'd15, 16'hABCD);
      @(negedge clk);
      wr_en    = 1'b1;
      wr_addr  = 4'd15;
      wr_data  = 16'h5555;
      rd_addr1 = 4'd15;
      rd_addr2 = 4'd15;
      #1;
      chk("r15_before_rst_nb", rd1_nb, 16'hABCD);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_async_rd1", rd1, 16'h0000);
      chk("rst_async_rd1_nb", rd1_nb, 16'h0000);
      chk("rst_onehot", oh, 16'h8000);
      @(posedge clk);
      #1;
      chk("rst_blocked_rd1", rd1, 16'h0000);
      chk("rst_blocked_rd2_nb", rd2_nb, 16'h0000);
      @(negedge clk);
      rst_n = 1'b1;
      wr_en = 1'b0;
      #1;
      chk("post_rst_rd1", rd1, 16'h0000);

      // Port independence and address swap
      write_reg(4'd3, 16'h0003);
      write_reg(4'd12, 16'h000C);
      rd_addr1 = 4'd3;
      rd_addr2 = 4'd12;
      #1;
      chk("indep_rd1", rd1, 16'h0003);
      chk("indep_rd2", rd2, 16'h000C);
      rd_addr1 = 4'd12;
      rd_addr2 = 4'd3;
      #1;
      chk("swap_rd1", rd1, 16'h000C);
      chk("swap_rd2", rd2, 16'h0003);
      chk("swap_rd1_nb", rd1_nb, 16'h000C);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
